audio_i2s_tx: RTL

AUDIO_I2S_TX -- requirements
Module: audio_i2s_tx

---
 rtl/audio_i2s_tx_pkg.sv | 14 +
 rtl/audio_i2s_tx_if.sv | 22 ++
 rtl/audio_i2s_tx_fifo.sv | 62 ++++++
 rtl/audio_i2s_tx.sv | 126 ++++++++++++
 4 files changed

// File: rtl/audio_i2s_tx_pkg.sv
// Shared types and constants for the I2S transmitter.
// Stereo sample word packs left in the upper half, right in the lower.
package audio_i2s_tx_pkg;

  localparam int FRAME_SLOTS = 32;
  localparam int SLOT_W = 5;
  localparam int DIV_W = 8;

  typedef struct packed {
    logic signed [15:0] l;
    logic signed [15:0] r;
  } stereo_t;

endpackage

// File: rtl/audio_i2s_tx_if.sv
// Valid/ready sample-pair bundle.
// The producer drives data/valid, the FIFO answers with ready.
interface audio_i2s_tx_if;
  import audio_i2s_tx_pkg::*;

  stereo_t data;
  logic    valid;
  logic    ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );

endinterface

// File: rtl/audio_i2s_tx_fifo.sv
// sample_fifo: small stereo-pair FIFO with registered ready.
// Ready is computed from next-state level so it never lags a pop.
module sample_fifo
  import audio_i2s_tx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  audio_i2s_tx_if.slave          push_if,
  input  logic                   pop_i,
  output stereo_t                head_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  stereo_t       mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic          rdy_q, rdy_d;
  logic          push, full_d;

  assign push = push_if.valid && rdy_q;

  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    if (push)  wr_d = wr_q + 1'b1;
    if (pop_i) rd_d = rd_q + 1'b1;
    lvl_d  = lvl_q + LW'(push) - LW'(pop_i);
    full_d = lvl_d == LW'(DEPTH);
    rdy_d  = !full_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
      rdy_q <= 1'b1;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
      rdy_q <= rdy_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= push_if.data;
  end

  assign push_if.ready = rdy_q;
  assign head_o  = mem_q[rd_q];
  assign empty_o = lvl_q == '0;
  assign level_o = lvl_q;

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S stereo transmitter: BCLK divider, 32-slot frame, MSB-first shifter.
// Slot 0 carries the last bit of the previous word (I2S one-bit delay).
module audio_i2s_tx
  import audio_i2s_tx_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        CLK_50M,
  input  logic                        RESET_N,
  input  logic                        enable,
  input  logic signed [15:0]          pcm_l,
  input  logic signed [15:0]          pcm_r,
  input  logic                        pcm_valid,
  output logic                        pcm_ready,
  output logic                        I2S_BCLK,
  output logic                        I2S_LRCK,
  output logic                        I2S_DATA,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        underrun
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  audio_i2s_tx_if pcm_if ();

  stereo_t head;
  logic    empty, pop;

  assign pcm_if.data  = '{l: pcm_l, r: pcm_r};
  assign pcm_if.valid = pcm_valid;
  assign pcm_ready    = pcm_if.ready;

  sample_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK_50M),
    .rst_ni  (RESET_N),
    .push_if (pcm_if.slave),
    .pop_i   (pop),
    .head_o  (head),
    .empty_o (empty),
    .level_o (fifo_level)
  );

  logic [DIV_W-1:0]  div_q, div_d;
  logic [SLOT_W-1:0] slot_q, slot_d, slot_nx;
  logic [31:0]       sr_q, sr_d;
  logic [31:0]       word_q, word_d, nxt_word;
  logic bclk_q, bclk_d, lrck_q, lrck_d;
  logic data_q, data_d, und_q, und_d;
  logic run_q, run_d;
  logic term, slot_edge, frame;

  always_comb begin
    term      = enable && (div_q == DIV_LAST);
    slot_edge = term && bclk_q;
    // first edge after enable always lands on slot 0
    slot_nx   = run_q ? slot_q + 1'b1 : '0;
    frame     = slot_edge && (slot_nx == '0);
    pop       = frame && !empty;
    nxt_word  = empty ? word_q : head;

    div_d  = term ? '0 : div_q + 1'b1;
    bclk_d = bclk_q ^ term;
    slot_d = slot_q;
    lrck_d = lrck_q;
    data_d = data_q;
    sr_d   = sr_q;
    word_d = word_q;
    run_d  = run_q;
    und_d  = 1'b0;

    if (slot_edge) begin
      slot_d = slot_nx;
      run_d  = 1'b1;
      lrck_d = slot_nx[SLOT_W-1];
      data_d = frame ? word_q[0] : sr_q[31];
      sr_d   = frame ? nxt_word : {sr_q[30:0], 1'b0};
      if (frame) begin
        word_d = nxt_word;
        und_d  = empty;
      end
    end

    if (!enable) begin
      div_d  = '0;
      bclk_d = 1'b0;
      slot_d = '0;
      lrck_d = 1'b0;
      data_d = 1'b0;
      run_d  = 1'b0;
      und_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK_50M or negedge RESET_N) begin
    if (!RESET_N) begin
      div_q  <= '0;
      slot_q <= '0;
      sr_q   <= '0;
      word_q <= '0;
      bclk_q <= 1'b0;
      lrck_q <= 1'b0;
      data_q <= 1'b0;
      und_q  <= 1'b0;
      run_q  <= 1'b0;
    end else begin
      div_q  <= div_d;
      slot_q <= slot_d;
      sr_q   <= sr_d;
      word_q <= word_d;
      bclk_q <= bclk_d;
      lrck_q <= lrck_d;
      data_q <= data_d;
      und_q  <= und_d;
      run_q  <= run_d;
    end
  end

  assign I2S_BCLK = bclk_q;
  assign I2S_LRCK = lrck_q;
  assign I2S_DATA = data_q;
  assign underrun = und_q;

endmodule
